// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl shared types: controller states, line geometry, address fields.
// Imported by dcache_sram and dcache_ctrl.
package dcache_ctrl_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_BYTES = 32;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int WORDS      = LINE_BYTES / 4;
    localparam int OFFSET_W   = $clog2(LINE_BYTES);
    localparam int WSEL_W     = OFFSET_W - 2;

    typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines);
        return ADDR_W - OFFSET_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: direct-mapped line storage with tag, valid and dirty bits.
// Combinational read at idx; word (store) and line (refill) writes on the edge.
module dcache_sram
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = 5,
    parameter int TAG_W     = 22
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx,
    output line_t             rd_line,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    input  logic              word_we,
    input  logic [WSEL_W-1:0] wsel,
    input  logic [WORD_W-1:0] wdata,
    input  logic              line_we,
    input  line_t             line_wdata,
    input  logic [TAG_W-1:0]  tag_wdata
);

    line_t             data_q [NUM_LINES];
    logic [TAG_W-1:0]  tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign rd_line  = data_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

    // Data array: refill replaces the whole line, a store hit patches one word.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            data_q[idx] <= line_wdata;
        end else if (word_we) begin
            data_q[idx][wsel] <= wdata;
        end
    end

    // Tag array is only meaningful under a set valid bit, so it is not reset.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[idx] <= tag_wdata;
        end
    end

    // Valid/dirty: refill gives a clean valid line, a store hit marks it dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking write-back, write-allocate direct-mapped data cache.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [255:0]      mem_data_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int IDX_W = idx_width(NUM_LINES);
    localparam int TAG_W = tag_width(NUM_LINES);

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic              unused_addr;

    line_t             rd_line;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              rd_dirty;

    state_t            state_q;
    state_t            state_d;
    line_t             fill_q;
    logic              hit;
    logic              word_we;
    logic              line_we;

    assign idx         = cpu_addr_i[OFFSET_W +: IDX_W];
    assign tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel        = cpu_addr_i[2 +: WSEL_W];
    assign unused_addr = ^cpu_addr_i[1:0];

    // Reset forces every access to look like a miss.
    assign hit = cpu_req_i & ~rst_i & rd_valid & (rd_tag == tag);

    assign cpu_data_o = rd_line[wsel];
    assign mem_data_o = rd_line;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx        (idx),
        .rd_line    (rd_line),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .word_we    (word_we),
        .wsel       (wsel),
        .wdata      (cpu_data_i),
        .line_we    (line_we),
        .line_wdata (fill_q),
        .tag_wdata  (tag)
    );

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Refill buffer holds the fetched line until the REFILL write.
    always_ff @(posedge clk_i) begin
        if (state_q == ALLOCATE && mem_ack_i) begin
            fill_q <= mem_data_i;
        end
    end

    // Next state, stall, memory request and array write enables.
    always_comb begin
        state_d     = state_q;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        word_we     = 1'b0;
        line_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cpu_stall_o = cpu_req_i & ~hit;
                word_we     = hit & cpu_we_i;
                if (cpu_req_i && !hit) begin
                    state_d = (rd_valid && rd_dirty) ? WRITEBACK
                                                     : ALLOCATE;
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {rd_tag, idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {tag, idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                cpu_stall_o = 1'b1;
                line_we     = 1'b1;
                state_d     = IDLE;
            end
        endcase
        if (rst_i) begin
            cpu_stall_o = cpu_req_i;
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            word_we     = 1'b0;
            line_we     = 1'b0;
        end
    end

`ifdef DCACHE_STATS_EN
    // Count IDLE hits (replays included) and miss entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state_q == IDLE && cpu_req_i) begin
            if (hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic
// checked against a line-level cache/memory model.
module tb_dcache_ctrl;

    localparam int NL = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic         mreq;
    logic         mwe;
    logic [31:0]  maddr;
    logic [255:0] mdo;
    logic [255:0] mdi;
    logic         mack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hcnt;
    logic [31:0]  mcnt;
`endif

    int total = 0;
    int bad   = 0;

    bit           mvalid [NL];
    bit           mdirty [NL];
    logic [21:0]  mtag   [NL];
    logic [255:0] mline  [NL];
    logic [255:0] memory [logic [31:0]];
    int           exp_hits = 0;
    int           exp_miss = 0;

    always #5 clk = ~clk;

    dcache_ctrl #(.NUM_LINES(NL)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (req),
        .cpu_we_i    (we),
        .cpu_addr_i  (addr),
        .cpu_data_i  (wdata),
        .cpu_data_o  (rdata),
        .cpu_stall_o (stall),
        .mem_req_o   (mreq),
        .mem_we_o    (mwe),
        .mem_addr_o  (maddr),
        .mem_data_o  (mdo),
        .mem_data_i  (mdi),
        .mem_ack_i   (mack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hcnt),
        .miss_cnt_o  (mcnt)
`endif
    );

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    function automatic logic [255:0] mem_rd(input logic [31:0] la);
        if (!memory.exists(la)) memory[la] = rand_line();
        return memory[la];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            mvalid[i] = 0;
            mdirty[i] = 0;
        end
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // One CPU access, acting as memory with ack after kwb/kal request cycles.
    task automatic do_access(input logic w, input logic [31:0] a,
                             input logic [31:0] d, input int kwb,
                             input int kal, input string nm,
                             output logic [31:0] got);
        logic [4:0]   idx;
        logic [21:0]  tg;
        int           word;
        bit           is_hit;
        bit           do_wb;
        logic [31:0]  wb_a;
        logic [255:0] wb_l;
        logic [31:0]  al_a;
        logic [255:0] al_l;
        logic [31:0]  exp_rd;
        int           exp_stall;
        int           nreq;
        int           ph;
        int           cnt;
        int           stalls;
        bit           done;
        bit           chk_drop;
        logic [31:0]  exp_a;
        bit           exp_we;
        int           k;

        idx    = a[9:5];
        tg     = a[31:10];
        word   = int'(a[4:2]);
        is_hit = mvalid[idx] && mtag[idx] == tg;
        do_wb  = !is_hit && mvalid[idx] && mdirty[idx];
        wb_a   = {mtag[idx], idx, 5'b0};
        wb_l   = mline[idx];
        al_a   = {a[31:5], 5'b0};
        al_l   = '0;
        if (!is_hit) begin
            if (do_wb) memory[wb_a] = wb_l;
            al_l = mem_rd(al_a);
            mline[idx]  = al_l;
            mtag[idx]   = tg;
            mvalid[idx] = 1;
            mdirty[idx] = 0;
            exp_miss++;
        end
        exp_hits++;
        exp_rd = mline[idx][word*32 +: 32];
        if (w) begin
            mline[idx][word*32 +: 32] = d;
            mdirty[idx] = 1;
        end
        exp_stall = is_hit ? 0 : 2 + kal + (do_wb ? kwb : 0);
        nreq      = is_hit ? 0 : (do_wb ? 2 : 1);

        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        got   = 'x;
        ph = 0; cnt = 0; stalls = 0; done = 0; chk_drop = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (chk_drop) begin
                total++;
                if (mreq !== 1'b0) begin
                    bad++;
                    $display("FAIL %s req_drop got=%b exp=0", nm, mreq);
                end
                chk_drop = 0;
            end
            if (!stall) begin
                done = 1;
                got  = rdata;
                if (!w) begin
                    total++;
                    if (rdata !== exp_rd) begin
                        bad++;
                        $display("FAIL %s rdata got=%h exp=%h",
                                 nm, rdata, exp_rd);
                    end
                end
            end else begin
                stalls++;
                if (mreq) begin
                    cnt++;
                    if (ph >= nreq) begin
                        total++; bad++;
                        $display("FAIL %s extra_req got=%h exp=none",
                                 nm, maddr);
                        mack = 1'b1;
                        mdi  = rand_line();
                    end else begin
                        exp_we = (ph == 0) && do_wb;
                        exp_a  = exp_we ? wb_a : al_a;
                        total++;
                        if (maddr !== exp_a || mwe !== exp_we) begin
                            bad++;
                            $display("FAIL %s mem_addr got=%h/%b exp=%h/%b",
                                     nm, maddr, mwe, exp_a, exp_we);
                        end
                        if (exp_we && cnt == 1) begin
                            total++;
                            if (mdo !== wb_l) begin
                                bad++;
                                $display("FAIL %s wb_line got=%h exp=%h",
                                         nm, mdo, wb_l);
                            end
                        end
                        k = exp_we ? kwb : kal;
                        if (cnt == k) begin
                            mack = 1'b1;
                            mdi  = exp_we ? rand_line() : al_l;
                            ph++;
                            cnt = 0;
                            if (ph == nreq) chk_drop = 1;
                        end
                    end
                end
            end
            tick();
            mack = 1'b0;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout got=stalled exp=done", nm);
        end else if (stalls != exp_stall) begin
            bad++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d",
                     nm, stalls, exp_stall);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h40;
        wdata = '0;
        mack = 1'b0;
        mdi  = '0;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (stall !== 1'b1 || mreq !== 1'b0 || mwe !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got=%b%b%b exp=100", stall, mreq, mwe);
        end
        tick();
        rst = 1'b0;
        req = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || mreq !== 1'b0) begin
            bad++;
            $display("FAIL idle_out got=%b%b exp=00", stall, mreq);
        end
`ifdef DCACHE_STATS_EN
        total++;
        if (hcnt !== 32'd0 || mcnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hcnt, mcnt);
        end
`endif
        tick();
    endtask

    task automatic test_directed();
        logic [255:0] l;
        logic [31:0]  got;
        l = rand_line();
        l[31:0]  = 32'hDEADBEEF;
        l[63:32] = 32'hDEADBEEF;
        memory[32'h40] = l;
        do_access(1'b0, 32'h40, '0, 1, 3, "load_miss", got);
        total++;
        if (got !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL first_load got=%h exp=deadbeef", got);
        end
        do_access(1'b1, 32'h40, 32'h12345678, 1, 1, "store_hit", got);
        do_access(1'b0, 32'h40, '0, 1, 1, "load_hit", got);
        total++;
        if (got !== 32'h12345678) begin
            bad++;
            $display("FAIL reload got=%h exp=12345678", got);
        end
        do_access(1'b0, 32'h440, '0, 2, 3, "evict_dirty", got);
        total++;
        if (memory[32'h40][31:0] !== 32'h12345678) begin
            bad++;
            $display("FAIL wb_model got=%h exp=12345678",
                     memory[32'h40][31:0]);
        end
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        total++;
        if (hcnt !== 32'd4 || mcnt !== 32'd2) begin
            bad++;
            $display("FAIL seq_cnt got=%0d/%0d exp=4/2", hcnt, mcnt);
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        bit          seen;
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h840;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mreq) seen = 1;
            tick();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL mid_req got=0 exp=1");
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (mreq !== 1'b0) begin
            bad++;
            $display("FAIL rst_mreq got=%b exp=0", mreq);
        end
        tick();
        rst  = 1'b0;
        req  = 1'b0;
        mack = 1'b1;
        mdi  = rand_line();
        model_reset();
        @(negedge clk);
        total++;
        if (mreq !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL stray_ack got=%b%b exp=00", mreq, stall);
        end
        tick();
        mack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (mreq !== 1'b0) begin
                bad++;
                $display("FAIL post_rst_req got=%b exp=0", mreq);
            end
            tick();
        end
`ifdef DCACHE_STATS_EN
        total++;
        if (hcnt !== 32'd0 || mcnt !== 32'd0) begin
            bad++;
            $display("FAIL mid_cnt got=%0d/%0d exp=0/0", hcnt, mcnt);
        end
`endif
        do_access(1'b0, 32'h40, '0, 1, 2, "miss_after_rst", got);
    endtask

    task automatic test_spurious_ack();
        logic [31:0] got;
        req  = 1'b0;
        mack = 1'b1;
        mdi  = rand_line();
        tick();
        mack = 1'b0;
        tick();
        do_access(1'b0, 32'h44, '0, 1, 1, "spur_hit", got);
        do_access(1'b0, 32'h1a0, '0, 1, 2, "spur_miss", got);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] got;
        for (int n = 0; n < 60; n++) begin
            a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'b00};
            do_access(1'($urandom_range(0, 1)), a, $urandom(),
                      $urandom_range(1, 4), $urandom_range(1, 4),
                      "random", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        logic [4:0]  i5;
        for (int i = 0; i < 4; i++) begin
            i5 = 5'(i);
            if (mvalid[i]) begin
                do_access(1'b1, {mtag[i], i5, 3'(i), 2'b00}, $urandom(),
                          1, 1, "b2b_st", got);
                do_access(1'b0, {mtag[i], i5, 3'(i), 2'b00}, '0,
                          1, 1, "b2b_ld", got);
            end
        end
        req = 1'b0;
        tick();
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        total++;
        if (hcnt !== 32'(exp_hits) || mcnt !== 32'(exp_miss)) begin
            bad++;
            $display("FAIL stats got=%0d/%0d exp=%0d/%0d",
                     hcnt, mcnt, exp_hits, exp_miss);
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
